// File: rtl/skein_inv_round_engine.sv
// ============================================================================
// Module      : skein_inv_round_engine
// Description : Iterative inverse of NUM_PAIRS Skein-1024/Threefish-1024
//               even+odd MIX/permute round pairs, one inverse Mix8 per clock.
//               Define SKEIN_INV_TWO_MIX_EN to cascade two inverse steps
//               per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skein_inv_round_engine #(
    parameter int NUM_PAIRS = 1
) (
    input  logic          clk,
    input  logic          nRst,
    input  logic          InValid,
    output logic          InReady,
    input  logic [1023:0] In,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [1023:0] Out,
    output logic          Busy
);

    localparam int c_steps = 8 * NUM_PAIRS;
    localparam int c_cw    = $clog2(c_steps + 1);
`ifdef SKEIN_INV_TWO_MIX_EN
    localparam int c_cycles = c_steps / 2;
`else
    localparam int c_cycles = c_steps;
`endif
    localparam logic [c_cw-1:0] c_last    = c_cw'(c_cycles - 1);
    localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);

    // Permutation tables, element j at bits [3j+2:3j].
    localparam logic [23:0] c_pe = {3'd0, 3'd2, 3'd1, 3'd3, 3'd7, 3'd5, 3'd6, 3'd4};
    localparam logic [23:0] c_qe = {3'd4, 3'd7, 3'd6, 3'd5, 3'd2, 3'd3, 3'd1, 3'd0};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_st;
    state_t              w_st_nxt;
    logic [1023:0]       r_state;
    logic [1023:0]       r_out;
    logic [c_cw-1:0]     r_cnt;
    logic [1023:0]       w_next;
    logic                w_last;

    // Rotation row for inverse step s mod 8 (Odd3..Odd0, Even3..Even0); R0 in the MSBs.
    function automatic logic [47:0] f_row(input logic [2:0] idx);
        case (idx)
            3'd0:    f_row = {6'd47, 6'd49, 6'd27, 6'd58, 6'd37, 6'd48, 6'd53, 6'd56};
            3'd1:    f_row = {6'd58, 6'd7,  6'd32, 6'd45, 6'd19, 6'd18, 6'd2,  6'd56};
            3'd2:    f_row = {6'd17, 6'd6,  6'd18, 6'd25, 6'd43, 6'd42, 6'd40, 6'd15};
            3'd3:    f_row = {6'd28, 6'd7,  6'd47, 6'd48, 6'd51, 6'd9,  6'd35, 6'd41};
            3'd4:    f_row = {6'd34, 6'd43, 6'd25, 6'd60, 6'd44, 6'd9,  6'd59, 6'd34};
            3'd5:    f_row = {6'd33, 6'd8,  6'd18, 6'd57, 6'd21, 6'd12, 6'd32, 6'd54};
            3'd6:    f_row = {6'd25, 6'd25, 6'd46, 6'd13, 6'd14, 6'd13, 6'd52, 6'd57};
            default: f_row = {6'd55, 6'd43, 6'd37, 6'd40, 6'd16, 6'd22, 6'd38, 6'd12};
        endcase
    endfunction

    function automatic logic [63:0] f_rotr(input logic [63:0] x, input logic [5:0] r);
        f_rotr = (x >> r) | (x << (7'd64 - {1'b0, r}));
    endfunction

    // State layout: word 2k holds E[k], word 2k+1 holds O[k].
    function automatic logic [1023:0] f_inv_step(input logic [1023:0] s, input logic [47:0] row);
        logic [7:0][63:0] ep;
        logic [7:0][63:0] op;
        logic [7:0][63:0] t;
        logic [7:0][63:0] o;
        logic [2:0]       pj;
        ep = '0;
        op = '0;
        t  = '0;
        o  = '0;
        for (int j = 0; j < 8; j++) begin
            ep[j] = s[128*j +: 64];
            op[j] = s[128*j+64 +: 64];
        end
        for (int j = 0; j < 8; j++) begin
            t[c_qe[3*j +: 3]] = ep[j];
        end
        for (int j = 0; j < 8; j++) begin
            pj    = c_pe[3*j +: 3];
            o[pj] = f_rotr(op[j] ^ t[pj], row[6*(7-pj) +: 6]);
        end
        for (int i = 0; i < 8; i++) begin
            f_inv_step[128*i +: 64]    = t[i] - o[i];
            f_inv_step[128*i+64 +: 64] = o[i];
        end
    endfunction

`ifdef SKEIN_INV_TWO_MIX_EN
    logic [1023:0] w_mid;
    always_comb begin
        w_mid  = f_inv_step(r_state, f_row({r_cnt[1:0], 1'b0}));
        w_next = f_inv_step(w_mid, f_row({r_cnt[1:0], 1'b1}));
    end
`else
    always_comb begin
        w_next = f_inv_step(r_state, f_row(r_cnt[2:0]));
    end
`endif

    assign w_last = (r_cnt == c_last);
    assign Out    = r_out;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_st <= ST_IDLE;
        end else begin
            r_st <= w_st_nxt;
        end
    end

    always_comb begin
        w_st_nxt = r_st;
        InReady  = 1'b0;
        OutValid = 1'b0;
        Busy     = 1'b0;
        case (r_st)
            ST_IDLE: begin
                InReady = 1'b1;
                if (InValid) begin
                    w_st_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                Busy = 1'b1;
                if (w_last) begin
                    w_st_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                Busy     = 1'b1;
                OutValid = 1'b1;
                if (OutReady) begin
                    w_st_nxt = ST_IDLE;
                end
            end
            default: begin
                w_st_nxt = ST_IDLE;
            end
        endcase
    end

    // Result goes to a dedicated register so Out stays put after the handshake.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= '0;
            r_out   <= '0;
            r_cnt   <= '0;
        end else if (r_st == ST_IDLE && InValid) begin
            r_state <= In;
            r_cnt   <= '0;
        end else if (r_st == ST_RUN) begin
            r_state <= w_next;
            r_cnt   <= r_cnt + c_cnt_one;
            if (w_last) begin
                r_out <= w_next;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_skein_inv_round_engine.sv
// ============================================================================
// Module      : tb_skein_inv_round_engine
// Description : Self-checking bench for skein_inv_round_engine (1 and 2 pairs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_skein_inv_round_engine;

`ifdef SKEIN_INV_TWO_MIX_EN
    localparam int LAT1 = 4;
    localparam int LAT2 = 8;
`else
    localparam int LAT1 = 8;
    localparam int LAT2 = 16;
`endif

    // Rows in inverse order: Odd3, Odd2, Odd1, Odd0, Even3, Even2, Even1, Even0.
    localparam int RTAB [8][8] = '{
        '{47, 49, 27, 58, 37, 48, 53, 56},
        '{58,  7, 32, 45, 19, 18,  2, 56},
        '{17,  6, 18, 25, 43, 42, 40, 15},
        '{28,  7, 47, 48, 51,  9, 35, 41},
        '{34, 43, 25, 60, 44,  9, 59, 34},
        '{33,  8, 18, 57, 21, 12, 32, 54},
        '{25, 25, 46, 13, 14, 13, 52, 57},
        '{55, 43, 37, 40, 16, 22, 38, 12}
    };
    localparam int PE [8] = '{4, 6, 5, 7, 3, 1, 2, 0};
    localparam int QE [8] = '{0, 1, 3, 2, 5, 6, 7, 4};

    logic          clk = 1'b0;
    logic          nrst;
    logic          inv1, ir1, ov1, or1, busy1;
    logic [1023:0] in1, out1;
    logic          inv2, ir2, ov2, or2, busy2;
    logic [1023:0] in2, out2;

    int            cyc = 0;
    int            n_vec = 0;
    int            n_err = 0;
    logic [1023:0] q1[$];
    logic [1023:0] q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    skein_inv_round_engine #(.NUM_PAIRS(1)) u_dut1 (
        .clk(clk), .nRst(nrst), .InValid(inv1), .InReady(ir1), .In(in1),
        .OutValid(ov1), .OutReady(or1), .Out(out1), .Busy(busy1)
    );

    skein_inv_round_engine #(.NUM_PAIRS(2)) u_dut2 (
        .clk(clk), .nRst(nrst), .InValid(inv2), .InReady(ir2), .In(in2),
        .OutValid(ov2), .OutReady(or2), .Out(out2), .Busy(busy2)
    );

    function automatic logic [63:0] rotl(input logic [63:0] x, input int r);
        return (x << r) | (x >> (64 - r));
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int r);
        return (x >> r) | (x << (64 - r));
    endfunction

    // Forward even round then odd round, repeated `pairs` times.
    function automatic logic [1023:0] fwd_model(input logic [1023:0] s, input int pairs);
        logic [63:0] e[8], o[8], t[8], ne[8], no[8];
        logic [1023:0] r;
        for (int i = 0; i < 8; i++) begin
            e[i] = s[128*i +: 64];
            o[i] = s[128*i+64 +: 64];
        end
        for (int p = 0; p < pairs; p++) begin
            for (int row = 7; row >= 0; row--) begin
                for (int i = 0; i < 8; i++) t[i] = e[i] + o[i];
                for (int j = 0; j < 8; j++) begin
                    ne[j] = t[QE[j]];
                    no[j] = t[PE[j]] ^ rotl(o[PE[j]], RTAB[row][PE[j]]);
                end
                e = ne;
                o = no;
            end
        end
        for (int i = 0; i < 8; i++) begin
            r[128*i +: 64]    = e[i];
            r[128*i+64 +: 64] = o[i];
        end
        return r;
    endfunction

    function automatic logic [1023:0] inv_model(input logic [1023:0] s, input int pairs);
        logic [63:0] e[8], o[8], t[8], o2[8];
        logic [1023:0] r;
        for (int i = 0; i < 8; i++) begin
            e[i] = s[128*i +: 64];
            o[i] = s[128*i+64 +: 64];
        end
        for (int st = 0; st < 8 * pairs; st++) begin
            for (int j = 0; j < 8; j++) t[QE[j]] = e[j];
            for (int j = 0; j < 8; j++) o2[PE[j]] = rotr(o[j] ^ t[PE[j]], RTAB[st % 8][PE[j]]);
            for (int i = 0; i < 8; i++) begin
                e[i] = t[i] - o2[i];
                o[i] = o2[i];
            end
        end
        for (int i = 0; i < 8; i++) begin
            r[128*i +: 64]    = e[i];
            r[128*i+64 +: 64] = o[i];
        end
        return r;
    endfunction

    function automatic int wd(input logic [1023:0] a, input logic [1023:0] b);
        for (int i = 0; i < 16; i++) if (a[64*i +: 64] !== b[64*i +: 64]) return i;
        return 0;
    endfunction

    function automatic logic [1023:0] rand_state();
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic drive1(input logic [1023:0] vec, input logic [1023:0] exp, output int t0);
        @(negedge clk);
        in1 = vec;
        inv1 = 1'b1;
        q1.push_back(exp);
        @(posedge clk);
        #1;
        t0 = cyc;
        inv1 = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec += 4;
        if (ir1 !== 1'b1) begin n_err++; $display("FAIL reset_inready: got %b want 1", ir1); end
        if (ov1 !== 1'b0) begin n_err++; $display("FAIL reset_outvalid: got %b want 0", ov1); end
        if (busy1 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy1); end
        if (out1 !== '0) begin n_err++; $display("FAIL reset_out: word %0d got %h want 0", wd(out1, '0), out1[64*wd(out1, '0) +: 64]); end
        nrst = 1'b1;
        @(negedge clk);
        n_vec += 2;
        if (ir2 !== 1'b1) begin n_err++; $display("FAIL reset_inready2: got %b want 1", ir2); end
        if (busy2 !== 1'b0) begin n_err++; $display("FAIL reset_busy2: got %b want 0", busy2); end
    endtask

    task automatic test_zero();
        int t0, lat;
        bit got;
        logic [1023:0] e;
        drive1('0, '0, t0);
        got = 0;
        for (int k = 0; k < 64 && !got; k++) begin @(negedge clk); if (ov1) got = 1; end
        lat = cyc - t0;
        n_vec++;
        if (!got || lat != LAT1) begin n_err++; $display("FAIL zero_latency: got %0d (valid %0b) want %0d", lat, got, LAT1); end
        e = q1.pop_front();
        n_vec++;
        if (out1 !== e) begin n_err++; $display("FAIL zero_out: word %0d got %h want %h", wd(out1, e), out1[64*wd(out1, e) +: 64], e[64*wd(out1, e) +: 64]); end
    endtask

    task automatic test_round_trip();
        int t0, lat;
        bit got;
        logic [1023:0] orig, e;
        for (int i = 0; i < 16; i++) orig[64*i +: 64] = 64'h0123456789ABCDEF ^ 64'(i);
        drive1(fwd_model(orig, 1), orig, t0);
        got = 0;
        for (int k = 0; k < 64 && !got; k++) begin @(negedge clk); if (ov1) got = 1; end
        e = q1.pop_front();
        n_vec++;
        if (!got || out1 !== e) begin n_err++; $display("FAIL rt_pair1: valid %0b word %0d got %h want %h", got, wd(out1, e), out1[64*wd(out1, e) +: 64], e[64*wd(out1, e) +: 64]); end
        @(negedge clk);
        in2 = fwd_model(orig, 2);
        inv2 = 1'b1;
        q2.push_back(orig);
        @(posedge clk);
        #1;
        t0 = cyc;
        inv2 = 1'b0;
        got = 0;
        for (int k = 0; k < 64 && !got; k++) begin @(negedge clk); if (ov2) got = 1; end
        lat = cyc - t0;
        n_vec++;
        if (!got || lat != LAT2) begin n_err++; $display("FAIL rt_pair2_latency: got %0d (valid %0b) want %0d", lat, got, LAT2); end
        e = q2.pop_front();
        n_vec++;
        if (out2 !== e) begin n_err++; $display("FAIL rt_pair2: word %0d got %h want %h", wd(out2, e), out2[64*wd(out2, e) +: 64], e[64*wd(out2, e) +: 64]); end
    endtask

    task automatic test_backpressure();
        int t0;
        bit got;
        logic [1023:0] orig, e, snap;
        or1 = 1'b0;
        orig = rand_state();
        drive1(fwd_model(orig, 1), orig, t0);
        got = 0;
        for (int k = 0; k < 64 && !got; k++) begin @(negedge clk); if (ov1) got = 1; end
        snap = out1;
        e = q1.pop_front();
        n_vec++;
        if (!got || out1 !== e) begin n_err++; $display("FAIL bp_out: valid %0b word %0d got %h want %h", got, wd(out1, e), out1[64*wd(out1, e) +: 64], e[64*wd(out1, e) +: 64]); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec += 3;
            if (ov1 !== 1'b1) begin n_err++; $display("FAIL bp_valid cycle %0d: got %b want 1", k, ov1); end
            if (out1 !== snap) begin n_err++; $display("FAIL bp_stable cycle %0d: word %0d got %h want %h", k, wd(out1, snap), out1[64*wd(out1, snap) +: 64], snap[64*wd(out1, snap) +: 64]); end
            if (ir1 !== 1'b0) begin n_err++; $display("FAIL bp_inready cycle %0d: got %b want 0", k, ir1); end
            inv1 = ~inv1;
            in1 = rand_state();
        end
        inv1 = 1'b0;
        or1 = 1'b1;
        @(negedge clk);
        n_vec += 3;
        if (busy1 !== 1'b0 || ir1 !== 1'b1) begin n_err++; $display("FAIL bp_release: busy %b inready %b want busy 0 inready 1", busy1, ir1); end
        if (ov1 !== 1'b0) begin n_err++; $display("FAIL bp_valid_drop: got %b want 0", ov1); end
        if (out1 !== snap) begin n_err++; $display("FAIL bp_hold: word %0d got %h want %h", wd(out1, snap), out1[64*wd(out1, snap) +: 64], snap[64*wd(out1, snap) +: 64]); end
    endtask

    task automatic test_back_to_back();
        int t0, t1, nres;
        bit acc2;
        logic [1023:0] a, b, e;
        a = rand_state();
        b = rand_state();
        @(negedge clk);
        in1 = fwd_model(a, 1);
        inv1 = 1'b1;
        q1.push_back(a);
        @(posedge clk);
        #1;
        t0 = cyc;
        t1 = 0;
        in1 = fwd_model(b, 1);
        q1.push_back(b);
        acc2 = 0;
        nres = 0;
        for (int k = 0; k < 80 && nres < 2; k++) begin
            @(negedge clk);
            if (acc2) inv1 = 1'b0;
            if (ov1) begin
                e = q1.pop_front();
                nres++;
                n_vec++;
                if (out1 !== e) begin n_err++; $display("FAIL b2b_out%0d: word %0d got %h want %h", nres, wd(out1, e), out1[64*wd(out1, e) +: 64], e[64*wd(out1, e) +: 64]); end
            end
            if (ir1 && inv1 && !acc2) begin
                acc2 = 1;
                t1 = cyc + 1;
            end
        end
        inv1 = 1'b0;
        n_vec++;
        if (nres != 2 || t1 - t0 != LAT1 + 2) begin n_err++; $display("FAIL b2b_period: got %0d results, spacing %0d want 2 results, spacing %0d", nres, t1 - t0, LAT1 + 2); end
        q1.delete();
    endtask

    task automatic test_reset_mid_run();
        int t0, lat;
        bit got;
        logic [1023:0] orig, e;
        orig = rand_state();
        drive1(fwd_model(orig, 1), orig, t0);
        repeat (3) @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        n_vec += 3;
        if (ov1 !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", ov1); end
        if (busy1 !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", busy1); end
        if (out1 !== '0) begin n_err++; $display("FAIL rst_mid_out: word %0d got %h want 0", wd(out1, '0), out1[64*wd(out1, '0) +: 64]); end
        q1.delete();
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ir1 !== 1'b1 || busy1 !== 1'b0) begin n_err++; $display("FAIL rst_mid_idle: inready %b busy %b want 1 0", ir1, busy1); end
        orig = rand_state();
        drive1(fwd_model(orig, 1), orig, t0);
        got = 0;
        for (int k = 0; k < 64 && !got; k++) begin @(negedge clk); if (ov1) got = 1; end
        lat = cyc - t0;
        e = q1.pop_front();
        n_vec++;
        if (!got || lat != LAT1 || out1 !== e) begin n_err++; $display("FAIL rst_mid_after: valid %0b latency %0d word %0d got %h want %h", got, lat, wd(out1, e), out1[64*wd(out1, e) +: 64], e[64*wd(out1, e) +: 64]); end
    endtask

    task automatic test_single_bit();
        int t0, lat;
        bit got;
        logic [1023:0] v, e;
        v = '0;
        v[15*64] = 1'b1;
        drive1(v, inv_model(v, 1), t0);
        got = 0;
        for (int k = 0; k < 64 && !got; k++) begin @(negedge clk); if (ov1) got = 1; end
        lat = cyc - t0;
        n_vec++;
        if (!got || lat != LAT1) begin n_err++; $display("FAIL bit_latency: got %0d (valid %0b) want %0d", lat, got, LAT1); end
        e = q1.pop_front();
        n_vec++;
        if (out1 !== e) begin n_err++; $display("FAIL bit_out: word %0d got %h want %h", wd(out1, e), out1[64*wd(out1, e) +: 64], e[64*wd(out1, e) +: 64]); end
        @(negedge clk);
    endtask

    initial begin
        nrst = 1'b0;
        inv1 = 1'b0;
        inv2 = 1'b0;
        or1  = 1'b1;
        or2  = 1'b1;
        in1  = '0;
        in2  = '0;
        test_reset();
        test_zero();
        test_round_trip();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_single_bit();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/skein_inv_round_engine.md
Name: skein_inv_round_engine

Overview:
- Iterative inverse of the Skein-1024/Threefish-1024 MIX/permute round pairs. The forward datapath runs an even round (4 Mix8 steps) followed by an odd round (4 Mix8 steps).
- This block undoes NUM_PAIRS such pairs, one inverse Mix8 per clock, and returns the pre-round 1024-bit state.
- Used for decryption and for self-check of the forward pipeline. Subkey injection and removal are outside this block.

Parameters:
- NUM_PAIRS, 1, number of even+odd round pairs to undo (1..16); total inverse steps N = 8*NUM_PAIRS.

Ports:
- clk  in  1  clock, rising edge.
- nRst  in  1  asynchronous active-low reset.
- InValid  in  1  input state valid.
- InReady  out  1  engine can accept a state.
- In  in  1024  ciphertext-side state, word i at bits [64i+63:64i].
- OutValid  out  1  result valid.
- OutReady  in  1  consumer accepts result.
- Out  out  1024  recovered state, same word layout as In.
- Busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync deassert from the system): state=IDLE, InReady=1, OutValid=0, Busy=0, Out=0, step counter=0, internal state register=0.
- Reset mid-operation: the in-flight block is discarded. No partial output is produced.
- Split:
  - On accept: E[k]=In word 2k and O[k]=In word 2k+1, for k=0..7.
  - On output: Out word 2k=E[k] and word 2k+1=O[k].
- Forward step being inverted (per mix, constants R0..R7, pe=(4,6,5,7,3,1,2,0), qe=(0,1,3,2,5,6,7,4)):
  - T[i]=E[i]+O[i].
  - E'[j]=T[qe(j)].
  - O'[j]=T[pe(j)] ^ ROTL64(O[pe(j)], R_pe(j)).
- Inverse step, all mod 2^64:
  - T[qe(j)]=E'[j].
  - O[pe(j)]=ROTR64(O'[j] ^ T[pe(j)], R_pe(j)).
  - E[i]=T[i]-O[i].
- Constant rows, applied in this order each pair (step s uses row s mod 8):
  - Odd3: 47,49,27,58,37,48,53,56
  - Odd2: 58,7,32,45,19,18,2,56
  - Odd1: 17,6,18,25,43,42,40,15
  - Odd0: 28,7,47,48,51,9,35,41
  - Even3: 34,43,25,60,44,9,59,34
  - Even2: 33,8,18,57,21,12,32,54
  - Even1: 25,25,46,13,14,13,52,57
  - Even0: 55,43,37,40,16,22,38,12
- FSM:
  - IDLE: InReady=1. On InValid&InReady, load the split state, clear the counter, go to RUN.
  - RUN: apply one inverse step per clock and increment the counter. After step N-1, go to DONE.
  - DONE: OutValid=1 and Out is driven from the register. Out stays stable while OutReady=0. On OutReady=1, go to IDLE.
- Handshakes: there is no overlap. InReady=0 in RUN and DONE, and InValid is ignored there. Out holds its last value after the handshake.
- Timing:
  - Accept at edge t0 gives OutValid high after edge tN.
  - Minimum block period is N+2 cycles.
  - Counter width is ceil(log2(N+1)). The counter never wraps within a block.

Optional Feature:
- SKEIN_INV_TWO_MIX_EN defined:
  - Two cascaded inverse steps per clock, using rows 2m and 2m+1.
  - RUN lasts N/2 cycles, so latency is N/2 and the period is N/2+2.
  - Results are bit-identical to the single-step build.
- SKEIN_INV_TWO_MIX_EN undefined: one step per clock as above.

Test Plan:
- All-zero In, NUM_PAIRS=1 -> OutValid exactly 8 cycles after accept, Out=0.
- Round trip:
  - Take the state with word i = 64'h0123456789ABCDEF ^ i.
  - Pass it through forward even round then odd round, and feed the result.
  - Out must equal the original words.
  - Repeat with NUM_PAIRS=2 using two forward pairs.
- Backpressure: hold OutReady=0 for 5 cycles in DONE -> Out and OutValid stable, InReady=0, InValid pulses ignored.
- Back-to-back: two vectors with OutReady=1 and InValid held -> second accepted at t0+10, both results match the model.
- Reset mid-RUN: assert nRst=0 at step 3 -> immediately OutValid=0, Busy=0, Out=0. After release, InReady=1 and a new block completes correctly.
- Single-bit In (word 15 = 1, others 0) with SKEIN_INV_TWO_MIX_EN -> OutValid 4 cycles after accept, Out equals the C model and the single-step build.
